br_resolve_ctrl: RTL and testbench

- Consumer side of the ID-stage branch unit: takes the per-cycle branch outcome (realj) and hazard distance (wait_seg[1:0]) for the branch in ID.
- Holds ID while operands are still in flight, resolves the branch once operands are forwardable, and issues a registered redirect request to IF with a valid/ready handshake.
- Keeps saturating performance counters.
- Sits between the ID stage, hazard/stall logic and the IF PC mux.

---
 rtl/br_resolve_ctrl.sv | 137 +++++++++++++
 tb/tb_br_resolve_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/br_resolve_ctrl.sv
// ID-stage branch resolution controller: holds ID on operand hazards, resolves
// the branch once operands are forwardable and issues a registered redirect to IF.
module br_resolve_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic              id_branch,
  input  logic [31:0]       id_target,
  input  logic [1:0]        wait_seg,
  input  logic              realj,
  input  logic              pipe_stall,
  input  logic              flush,
  input  logic              if_ready,
  output logic              id_stall,
  output logic              br_valid,
  output logic [31:0]       br_target,
  output logic              br_resolved,
  output logic              br_taken,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned WS_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

  state_e            state_q;
  logic [WS_W-1:0]   cnt_q;
  logic              br_valid_q;
  logic [31:0]       br_target_q;
  logic              br_resolved_q;
  logic              br_taken_q;
  logic [CNT_W-1:0]  taken_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic              br_c;
  logic [WS_W-1:0]   ws_c;
  logic              id_stall_c;
  logic              resolve_c;

  // Branch qualification, hazard distance clamp (3 behaves as 2) and ID hold
  always_comb begin
    br_c       = id_valid & id_branch;
    ws_c       = (wait_seg == 2'd3) ? 2'd2 : wait_seg;
    id_stall_c = 1'b0;
    resolve_c  = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_IDLE: begin
          id_stall_c = br_c & (ws_c != 2'd0);
          resolve_c  = br_c & (ws_c == 2'd0) & ~pipe_stall;
        end
        ST_WAIT:  id_stall_c = 1'b1;
        ST_REDIR: id_stall_c = br_c;
        default:  id_stall_c = 1'b0;
      endcase
    end
  end

  // Control state, redirect handshake, resolution pulse and saturating counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      br_valid_q    <= 1'b0;
      br_target_q   <= '0;
      br_resolved_q <= 1'b0;
      br_taken_q    <= 1'b0;
      taken_cnt_q   <= '0;
      stall_cnt_q   <= '0;
    end else begin
      br_resolved_q <= 1'b0;
      br_taken_q    <= 1'b0;
      if (id_stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        br_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (br_c && (ws_c != 2'd0) && !pipe_stall) begin
              cnt_q   <= ws_c;
              state_q <= ST_WAIT;
            end else if (resolve_c) begin
              br_resolved_q <= 1'b1;
              br_taken_q    <= realj;
              if (realj) begin
                br_target_q <= id_target;
                br_valid_q  <= 1'b1;
                state_q     <= ST_REDIR;
                if (taken_cnt_q != {CNT_W{1'b1}}) begin
                  taken_cnt_q <= taken_cnt_q + CNT_W'(1);
                end
              end
            end
          end
          ST_WAIT: begin
            if (!pipe_stall) begin
              cnt_q <= cnt_q - WS_W'(1);
              if (cnt_q <= WS_W'(1)) begin
                state_q <= ST_IDLE;
              end
            end
          end
          ST_REDIR: begin
            if (if_ready) begin
              br_valid_q <= 1'b0;
              state_q    <= ST_IDLE;
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            br_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign id_stall    = id_stall_c;
  assign br_valid    = br_valid_q;
  assign br_target   = br_target_q;
  assign br_resolved = br_resolved_q;
  assign br_taken    = br_taken_q;
  assign taken_cnt   = taken_cnt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Bench for br_resolve_ctrl: directed scenarios then random traffic, checked
// against a cycle model of branch hazards, redirects and event counts.
module tb_br_resolve_ctrl;

  logic        clk;
  logic        resetn;
  logic        id_valid;
  logic        id_branch;
  logic [31:0] id_target;
  logic [1:0]  wait_seg;
  logic        realj;
  logic        pipe_stall;
  logic        flush;
  logic        if_ready;

  logic        a_stall, a_valid, a_res, a_tk;
  logic [31:0] a_tgt;
  logic [15:0] a_tcnt, a_scnt;
  logic        b_stall, b_valid, b_res, b_tk;
  logic [31:0] b_tgt;
  logic [1:0]  b_tcnt, b_scnt;

  br_resolve_ctrl #(.CNT_W(16)) u_dut16 (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_branch(id_branch),
    .id_target(id_target), .wait_seg(wait_seg), .realj(realj),
    .pipe_stall(pipe_stall), .flush(flush), .if_ready(if_ready),
    .id_stall(a_stall), .br_valid(a_valid), .br_target(a_tgt),
    .br_resolved(a_res), .br_taken(a_tk), .taken_cnt(a_tcnt), .stall_cnt(a_scnt)
  );

  br_resolve_ctrl #(.CNT_W(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_branch(id_branch),
    .id_target(id_target), .wait_seg(wait_seg), .realj(realj),
    .pipe_stall(pipe_stall), .flush(flush), .if_ready(if_ready),
    .id_stall(b_stall), .br_valid(b_valid), .br_target(b_tgt),
    .br_resolved(b_res), .br_taken(b_tk), .taken_cnt(b_tcnt), .stall_cnt(b_scnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: hazard cycles still owed, pending redirect, event totals
  int          m_wait_left;
  bit          m_redirect;
  logic [31:0] m_tgt;
  bit          m_res;
  bit          m_tk;
  int          m_taken_total;
  int          m_stall_total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic int hazard(input logic [1:0] ws);
    return (ws == 2'd3) ? 2 : int'(ws);
  endfunction

  task automatic model_reset();
    m_wait_left   = 0;
    m_redirect    = 0;
    m_tgt         = 32'h0;
    m_res         = 0;
    m_tk          = 0;
    m_taken_total = 0;
    m_stall_total = 0;
  endtask

  function automatic bit model_stall();
    bit br;
    br = id_valid & id_branch;
    if (flush)            return 1'b0;
    if (m_wait_left > 0)  return 1'b1;
    if (m_redirect)       return br;
    return br && (hazard(wait_seg) != 0);
  endfunction

  task automatic model_step(input bit stalled);
    bit br;
    int hz;
    br    = id_valid & id_branch;
    hz    = hazard(wait_seg);
    m_res = 0;
    m_tk  = 0;
    if (stalled) m_stall_total++;
    if (flush) begin
      m_wait_left = 0;
      m_redirect  = 0;
    end else if (m_wait_left > 0) begin
      if (!pipe_stall) m_wait_left--;
    end else if (m_redirect) begin
      if (if_ready) m_redirect = 0;
    end else if (br && !pipe_stall) begin
      if (hz != 0) begin
        m_wait_left = hz;
      end else begin
        m_res = 1;
        m_tk  = realj;
        if (realj) begin
          m_redirect = 1;
          m_tgt      = id_target;
          m_taken_total++;
        end
      end
    end
  endtask

  task automatic compare_all(input bit exp_stall);
    check("w16 id_stall",    32'(a_stall), 32'(exp_stall));
    check("w16 br_valid",    32'(a_valid), 32'(m_redirect));
    if (m_redirect) check("w16 br_target", a_tgt, m_tgt);
    check("w16 br_resolved", 32'(a_res),   32'(m_res));
    check("w16 br_taken",    32'(a_tk),    32'(m_tk));
    check("w16 taken_cnt",   32'(a_tcnt),  32'(sat(m_taken_total, 16)));
    check("w16 stall_cnt",   32'(a_scnt),  32'(sat(m_stall_total, 16)));
    check("w2 id_stall",     32'(b_stall), 32'(exp_stall));
    check("w2 br_valid",     32'(b_valid), 32'(m_redirect));
    if (m_redirect) check("w2 br_target", b_tgt, m_tgt);
    check("w2 br_resolved",  32'(b_res),   32'(m_res));
    check("w2 br_taken",     32'(b_tk),    32'(m_tk));
    check("w2 taken_cnt",    32'(b_tcnt),  32'(sat(m_taken_total, 2)));
    check("w2 stall_cnt",    32'(b_scnt),  32'(sat(m_stall_total, 2)));
  endtask

  // One clock: drive after the edge, compare at the falling edge, advance model
  task automatic step(input bit v, input bit b, input logic [31:0] t, input logic [1:0] ws,
                      input bit rj, input bit ps, input bit fl, input bit rdy);
    bit s;
    id_valid   = v;
    id_branch  = b;
    id_target  = t;
    wait_seg   = ws;
    realj      = rj;
    pipe_stall = ps;
    flush      = fl;
    if_ready   = rdy;
    @(negedge clk);
    s = model_stall();
    compare_all(s);
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    resetn = 1'b0;
    id_valid = 0; id_branch = 0; id_target = '0; wait_seg = '0;
    realj = 0; pipe_stall = 0; flush = 0; if_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all(1'b0);
    check("reset br_valid const", 32'(a_valid), 32'h0);
    check("reset br_target const", a_tgt, 32'h0);
    resetn = 1'b1;
    #1;

    // Taken, no hazard, IF ready: one-cycle redirect
    step(1, 1, 32'hBFC0_0100, 2'd0, 1, 0, 0, 1);
    check("taken target const", a_tgt, 32'hBFC0_0100);
    check("taken pulse const", 32'(a_res & a_tk & a_valid), 32'h1);
    idle(1'b1);
    idle(1'b1);

    // Load-in-EC hazard then not taken
    step(1, 1, 32'h1000, 2'd2, 0, 0, 0, 0);
    step(1, 1, 32'h1000, 2'd2, 0, 0, 0, 0);
    step(1, 1, 32'h1000, 2'd2, 0, 0, 0, 0);
    step(1, 1, 32'h1000, 2'd0, 0, 0, 0, 0);
    idle(1'b0);
    check("ec hazard stall_cnt const", 32'(a_scnt), 32'd3);

    // Redirect held while IF backs off
    step(1, 1, 32'h2468_ACE0, 2'd0, 1, 0, 0, 0);
    repeat (3) idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Single-cycle hazard frozen by downstream stall
    step(1, 1, 32'h3000, 2'd1, 1, 0, 0, 0);
    repeat (3) step(1, 1, 32'h3000, 2'd1, 1, 1, 0, 0);
    step(1, 1, 32'h3000, 2'd1, 1, 0, 0, 0);
    step(1, 1, 32'h3000, 2'd0, 1, 1, 0, 0);
    step(1, 1, 32'h3000, 2'd0, 1, 0, 0, 0);
    step(1, 1, 32'h3004, 2'd0, 0, 0, 0, 1);
    idle(1'b1);

    // Flush during WAIT, flush during REDIR, wait_seg=3 clamp
    step(1, 1, 32'h4000, 2'd3, 1, 0, 0, 0);
    step(1, 1, 32'h4000, 2'd3, 1, 0, 1, 1);
    idle(1'b0);
    step(1, 1, 32'h5000, 2'd0, 1, 0, 0, 0);
    step(1, 1, 32'h5004, 2'd0, 1, 1, 1, 1);
    idle(1'b0);
    step(1, 1, 32'h6000, 2'd3, 1, 0, 0, 0);
    step(1, 1, 32'h6000, 2'd3, 1, 0, 0, 0);
    step(1, 1, 32'h6000, 2'd3, 1, 0, 0, 0);
    step(1, 1, 32'h6000, 2'd0, 1, 0, 0, 0);
    idle(1'b1);

    // Five taken branches saturate the narrow counter
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 32'h7000 + 32'(i * 4), 2'd0, 1, 0, 0, 0);
      idle(1'b1);
    end
    check("narrow taken_cnt sat const", 32'(b_tcnt), 32'd3);

    // Async reset while a redirect is pending
    step(1, 1, 32'h8000, 2'd0, 1, 0, 0, 0);
    idle(1'b0);
    resetn = 1'b0;
    #1;
    model_reset();
    compare_all(1'b0);
    check("mid-redir reset valid const", 32'(a_valid | b_valid), 32'h0);
    #1;
    resetn = 1'b1;
    #1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0), $urandom(),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
